// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN datapath widths and the saturating ReLU used by the MAC and
// pointwise stages.
package cnn_pkg;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 16;
  localparam int TAPS   = 25;
  localparam int IDX_W  = 5;
  // Works on a 64-bit sign-extended value so any stage width can reuse it.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] a,
                                                  input int out_w, input logic relu_en);
    logic signed [63:0] hi, lo, v;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    v = (relu_en && a < 64'sd0) ? 64'sd0 : a;
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/mac_sat_out.sv
// mac_sat_out: one-entry result register with saturation/ReLU and valid/ready
// handshake; also tracks the sticky end-of-layer flag.
module mac_sat_out
  import cnn_pkg::*;
#(
  parameter int SUM_W   = 24,
  parameter int RES_W   = 16,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic signed [SUM_W-1:0] sum_i,
  input  logic                    last_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic signed [RES_W-1:0] data_o,
  output logic                    last_o,
  output logic                    done_o
);
  logic valid_q, valid_d, last_q, last_d, done_q, done_d, consume;
  logic signed [RES_W-1:0] data_q, data_d;
  logic signed [63:0] sat;
  always_comb begin
    consume = valid_q && ready_i;
    sat = sat_relu(64'(sum_i), RES_W, RELU_EN);
    valid_d = load_i || (valid_q && !consume);
    data_d = load_i ? RES_W'(sat) : data_q;
    last_d = load_i ? last_i : last_q;
    done_d = done_q || (consume && last_q);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign done_o  = done_q;
endmodule

// File: rtl/window_mac_25.sv
// window_mac_25: signed MAC over one 5x5 window, one tap per beat, with tap-order
// checking and a valid/ready result register.
module window_mac_25 #(
  parameter int DATA_W  = cnn_pkg::DATA_W,
  parameter int ACC_W   = cnn_pkg::ACC_W,
  parameter int OUT_W   = cnn_pkg::OUT_W,
  parameter int TAPS    = cnn_pkg::TAPS,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               tap_idx,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] weight,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     seq_err,
  output logic                     layer_done
);
  localparam logic [4:0] LAST_IDX = 5'(TAPS - 1);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_x, sum, acc_q, acc_d;
  logic [4:0] exp_q, exp_d, nxt;
  logic seq_q, seq_d, is_last, accept;
  always_comb begin
    prod = pixel * weight;
    prod_x = ACC_W'(prod);
    sum = acc_q + prod_x;
    is_last = tap_idx == LAST_IDX;
    // Only the last tap can stall: it needs the result register free.
    in_ready = !(is_last && out_valid && !out_ready);
    accept = in_valid && in_ready;
    nxt = 5'((6'(tap_idx) + 6'd1) % 6'(TAPS));
    acc_d = !accept ? acc_q : (is_last ? '0 : (tap_idx == '0 ? prod_x : sum));
    exp_d = accept ? nxt : exp_q;
    seq_d = seq_q || (accept && tap_idx != exp_q);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
      exp_q <= '0;
      seq_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      exp_q <= exp_d;
      seq_q <= seq_d;
    end
  end
  assign seq_err = seq_q;
  mac_sat_out #(.SUM_W(ACC_W), .RES_W(OUT_W), .RELU_EN(RELU_EN)) u_out (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept && is_last),
    .sum_i  (sum),
    .last_i (in_last),
    .ready_i(out_ready),
    .valid_o(out_valid),
    .data_o (out_data),
    .last_o (out_last),
    .done_o (layer_done)
  );
endmodule

// File: tb/tb_window_mac_25.sv
// tb_window_mac_25: randomized and directed windows; results checked through a
// scoreboard queue against an integer window-sum model, on ReLU and non-ReLU copies.
module tb_window_mac_25;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [4:0] tap_idx = '0;
  logic signed [7:0] pixel = '0, weight = '0;
  logic in_ready, out_valid, out_last, seq_err, layer_done;
  logic signed [15:0] out_data;
  logic in_ready0, out_valid0, out_last0, seq_err0, layer_done0;
  logic signed [15:0] out_data0;
  int n_cmp = 0, n_bad = 0;
  typedef struct {int d_relu; int d_raw; bit last;} exp_t;
  exp_t q[$];
  int wsum = 0, exp_idx = 0;
  bit m_seq = 0, m_done = 0, rnd_ready = 0;

  window_mac_25 #(.RELU_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .tap_idx(tap_idx),
    .pixel(pixel), .weight(weight), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .seq_err(seq_err),
    .layer_done(layer_done));
  window_mac_25 #(.RELU_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .tap_idx(tap_idx),
    .pixel(pixel), .weight(weight), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0), .seq_err(seq_err0),
    .layer_done(layer_done0));

  always #5 clk = ~clk;

  task automatic check(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sat(int s, bit relu);
    if (relu && s < 0) s = 0;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic void accept_model(int idx, int p, int w, bit last);
    if (idx != exp_idx) m_seq = 1;
    exp_idx = (idx + 1) % 25;
    wsum = (idx == 0) ? p * w : wsum + p * w;
    if (idx == 24) begin
      q.push_back('{sat(wsum, 1), sat(wsum, 0), last});
      wsum = 0;
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_result: got %0d, expected no result", out_data);
      end else begin
        e = q.pop_front();
        check("out_data_relu", out_data, e.d_relu);
        check("out_data_raw", out_data0, e.d_raw);
        check("out_last", out_last, e.last);
        if (e.last) m_done = 1;
      end
    end
  end

  always @(posedge clk) if (rnd_ready) begin
    #1 out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic beat(int idx, int p, int w, bit last);
    int guard = 0;
    tap_idx = 5'(idx); pixel = 8'(p); weight = 8'(w); in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin guard++; @(negedge clk); end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_timeout: in_ready got 0, expected 1");
    end else accept_model(idx, p, w, last);
    @(posedge clk); #1 in_valid = 1'b0;
    check("seq_err", seq_err, m_seq);
    check("layer_done", layer_done, m_done);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    wsum = 0; exp_idx = 0; m_seq = 0; m_done = 0; q.delete();
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    int guard;
    int p0, w0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_layer_done", layer_done, 0);
    check("rst_in_ready", in_ready, 1);
    // All ones: result 25, valid for exactly one cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 25; i++) beat(i, 1, 1, 0);
    check("ones_valid", out_valid, 1);
    check("ones_data", out_data, 25);
    idle(1);
    check("ones_valid_drop", out_valid, 0);
    // Saturation and ReLU corners.
    for (int i = 0; i < 25; i++) beat(i, 127, 127, 0);
    for (int i = 0; i < 25; i++) beat(i, -128, 127, 0);
    idle(2);
    // Back-to-back with downstream stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 25; i++) beat(i, rnd8(), rnd8(), 0);
    for (int i = 0; i < 24; i++) beat(i, rnd8(), rnd8(), 0);
    p0 = rnd8(); w0 = rnd8();
    tap_idx = 5'd24; pixel = 8'(p0); weight = 8'(w0); in_last = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("unstall_in_ready", in_ready, 1);
    accept_model(24, p0, w0, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    check("b2b_second_loaded", out_valid, 1);
    idle(2);
    // Skipped tap 11.
    for (int i = 0; i < 25; i++) if (i != 11) beat(i, rnd8(), rnd8(), 0);
    check("seq_err_set", seq_err, 1);
    idle(2);
    // Reset mid-window, then a clean 2x3 window.
    for (int i = 0; i < 14; i++) beat(i, rnd8(), rnd8(), 0);
    do_reset();
    for (int i = 0; i < 25; i++) beat(i, 2, 3, 0);
    check("post_rst_data", out_data, 150);
    check("post_rst_seq_err", seq_err, 0);
    idle(2);
    // Reset drops a held result.
    out_ready = 1'b0;
    for (int i = 0; i < 25; i++) beat(i, rnd8(), rnd8(), 0);
    check("held_valid", out_valid, 1);
    do_reset();
    check("rst_drop_valid", out_valid, 0);
    out_ready = 1'b1;
    // Randomized windows with gaps and random backpressure.
    rnd_ready = 1;
    for (int wn = 0; wn < 12; wn++)
      for (int i = 0; i < 25; i++) begin
        if ($urandom_range(0, 4) == 0) idle(1);
        beat(i, rnd8(), rnd8(), 0);
      end
    rnd_ready = 0;
    @(posedge clk); #2 out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin guard++; @(posedge clk); end
    #1 check("drain_queue_left", q.size(), 0);
    // Final window of the layer.
    out_ready = 1'b0;
    for (int i = 0; i < 25; i++) beat(i, rnd8(), rnd8(), 1);
    idle(2);
    check("held_out_last", out_last, 1);
    check("done_before_consume", layer_done, 0);
    out_ready = 1'b1;
    idle(1);
    check("done_after_consume", layer_done, 1);
    for (int i = 0; i < 25; i++) beat(i, rnd8(), rnd8(), 0);
    idle(2);
    check("done_sticky", layer_done, 1);
    check("final_queue_left", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/window_mac_25.md
# window_mac_25

Signed multiply-accumulate stage for one 5×5 convolution window, fed one tap per beat in 0..24 order by the upstream 25-state tap counter. Accumulates 25 pixel×weight products and applies optional ReLU and saturation. Presents each finished window result through a one-entry valid/ready output register to the downstream activation buffer. Flags tap-sequence errors and signals end-of-layer.

## Interface
- DATA_W, 8: signed width of pixel and weight inputs
- ACC_W, 24: signed accumulator width; must be ≥ 2·DATA_W+5
- OUT_W, 16: signed output width after saturation
- TAPS, 25: taps per window; the last tap index is TAPS-1
- RELU_EN, 1: 1 clamps negative results to 0
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- in_valid  in  1  tap beat valid
- in_ready  out  1  tap beat accepted when in_valid && in_ready
- tap_idx  in  5  tap index, 0..TAPS-1 (the upstream counter state)
- pixel  in  DATA_W  signed pixel
- weight  in  DATA_W  signed weight
- in_last  in  1  the beat belongs to the final window of the layer (upstream final-filter flag)
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  OUT_W  saturated (and optionally ReLU'd) window sum
- out_last  out  1  result is the layer's final window
- seq_err  out  1  sticky: an out-of-order tap was accepted
- layer_done  out  1  sticky: final window result consumed

## Operation
- The product is `pixel*weight`, signed and full 2·DATA_W wide, then sign-extended to ACC_W.
- On an accepted beat with tap_idx==0: `acc <= product`. For any other index: `acc <= acc + product`. Arithmetic wraps at ACC_W and never overflows for legal ACC_W.
- On an accepted beat with tap_idx==TAPS-1:
  - `sum = acc + product`.
  - When RELU_EN is set and sum<0, sum becomes 0.
  - sum saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - The result loads into out_data with out_valid=1 and out_last=in_last.
  - acc clears to 0.
- in_ready is 1 except when tap_idx==TAPS-1 && out_valid && !out_ready. A stall can only happen on the last tap.
- Sequence check:
  - An internal expected index exp counts 0..TAPS-1 and wraps.
  - On an accepted beat with tap_idx!=exp: seq_err sets, and the accumulator follows the rules above using tap_idx.
  - exp then resynchronizes to tap_idx+1, wrapping at TAPS.
- tap_idx > TAPS-1 is treated as a sequence error. Its product is added and the beat is not treated as last.
- layer_done sets on the consume handshake of a result with out_last=1. Only reset clears it.
- Output register states:
  - EMPTY (out_valid=0) goes to FULL when a last tap is accepted.
  - FULL goes to EMPTY on consume with no simultaneous last tap.
  - FULL stays FULL on consume plus a simultaneous last tap, with the new result loaded.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, seq_err=0, layer_done=0, acc=0, exp=0. in_ready=1 after reset.
- Latency: a last tap accepted at edge N gives out_valid=1 with the result valid after edge N.
- Throughput: one tap per cycle. Back-to-back windows sustain 1 result per TAPS cycles when out_ready is held at 1.
- A consume and a last-tap accept in the same cycle: the old result is consumed and the new result loads. There is no bubble.
- layer_done is 1 from the edge of the out_last consume.
- Reset asserted mid-window discards the partial acc and any held result. The first accepted beat after reset must start at tap 0, otherwise seq_err is raised.
- in_valid=0 cycles inside a window hold acc and exp.

## Structure
- Shared package `cnn_pkg`: DATA_W, ACC_W, OUT_W, TAPS constants and a `sat_relu` function (acc to OUT_W). The same function is reused by later pointwise stages.
- Sub-module `mac_sat_out`: the output register and saturation/ReLU with its valid/ready handshake. Everything else stays in the top level.

## Test plan
- 25 beats, all pixel=1, weight=1, out_ready=1 → out_data=25 one cycle after tap 24, out_valid held for exactly one cycle.
- 25 beats, pixel=127, weight=127, OUT_W=16 → sum 403225 saturates to out_data=32767. With pixel=-128, weight=127 and RELU_EN=1 → out_data=0. With RELU_EN=0 → out_data=-32768.
- Two windows back-to-back with out_ready=0 → first result held, in_ready=0 on the second window's tap 24. Raise out_ready → first result consumed and second loaded in the same cycle, with no lost or duplicated result.
- Tap sequence 0..10, 12..24 → seq_err=1 from the beat with tap 12 onward. The result still equals the sum of the 24 products.
- Reset (reset=0 for 1 cycle) after tap 13 of a window, then a full window of all 2×3 products → out_data=150. seq_err=0, with no residue from the discarded partial window.
- Final window with in_last=1 → out_last=1. layer_done rises only on the consume edge and stays 1 through further windows.
